// File: rtl/ram_copy_dma.sv
`default_nettype none
// ============================================================================
// Module      : ram_copy_dma
// Description : Bus initiator that copies a block of 32-bit words from a
//               source to a destination address in data RAM, one read and
//               one write per word, behind a request/grant arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_copy_dma #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             mem_req_o,
  input  logic             mem_gnt_i,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  input  logic [31:0]      mem_data_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] C_CNT_ONE = LEN_W'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_src_ptr;
  logic [31:0]      r_dst_ptr;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_buf;

  // Byte-offset bits of the start addresses are dropped on load.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{src_addr_i[1:0], dst_addr_i[1:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode and memory-side outputs, derived only from state and registers.
  always_comb begin
    w_state_next = r_state;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = 32'h0;
    mem_data_o   = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_state_next = (len_i != '0) ? S_READ : S_DONE;
      end
      S_READ: begin
        busy_o     = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = r_src_ptr;
        if (abort_i)        w_state_next = S_IDLE;
        else if (mem_gnt_i) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        busy_o     = 1'b1;
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = r_dst_ptr;
        mem_data_o = r_buf;
        // A granted write commits in the RAM even when abort arrives with it.
        if (abort_i)        w_state_next = S_IDLE;
        else if (mem_gnt_i) w_state_next = (r_cnt == C_CNT_ONE) ? S_DONE : S_READ;
      end
      S_DONE: begin
        busy_o       = 1'b1;
        done_o       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Pointer, counter and data-buffer updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_ptr <= 32'h0;
      r_dst_ptr <= 32'h0;
      r_cnt     <= '0;
      r_buf     <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_src_ptr <= {src_addr_i[31:2], 2'b00};
            r_dst_ptr <= {dst_addr_i[31:2], 2'b00};
            r_cnt     <= len_i;
          end
        end
        S_READ: begin
          if (mem_gnt_i && !abort_i) r_buf <= mem_data_i;
        end
        S_WRITE: begin
          if (mem_gnt_i) begin
            r_src_ptr <= r_src_ptr + 32'd4;
            r_dst_ptr <= r_dst_ptr + 32'd4;
            r_cnt     <= r_cnt - C_CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_copy_dma.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ram_copy_dma
// Description : Self-checking bench for ram_copy_dma with a RAM responder and
//               a word-level copy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_copy_dma;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [31:0]      src_addr_i = 32'h0;
  logic [31:0]      dst_addr_i = 32'h0;
  logic [LEN_W-1:0] len_i = '0;
  logic             busy_o, done_o, mem_req_o, mem_we_o;
  logic             mem_gnt_i = 1'b1;
  logic [31:0]      mem_addr_o, mem_data_o;
  logic [31:0]      mem_data_i;

  ram_copy_dma #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM responder: 1024 words, combinational read, write on granted edge.
  logic [31:0] ram [0:1023];
  logic [31:0] mdl [0:1023];
  assign mem_data_i = ram[mem_addr_o[11:2]];
  always @(posedge clk)
    if (mem_req_o && mem_gnt_i && mem_we_o) ram[mem_addr_o[11:2]] <= mem_data_o;

  function automatic int idx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  // Grant generator: 0 = always, 1 = pattern 1,0,0 repeating, 2 = random.
  int gnt_mode = 0;
  int gcyc = 0;
  always @(posedge clk) begin
    #1;
    gcyc++;
    case (gnt_mode)
      0:       mem_gnt_i = 1'b1;
      1:       mem_gnt_i = (gcyc % 3 == 0);
      default: mem_gnt_i = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: granted accesses and output stability while stalled.
  logic [64:0] obs_q[$];
  int          stall_viol = 0;
  logic        p_req = 1'b0, p_gnt = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = 32'h0, p_data = 32'h0;
  always @(negedge clk) begin
    if (mem_req_o && mem_gnt_i)
      obs_q.push_back({mem_we_o, mem_addr_o, mem_we_o ? mem_data_o : mem_data_i});
    if (!rst && p_req && !p_gnt && mem_req_o &&
        ({mem_we_o, mem_addr_o, mem_data_o} != {p_we, p_addr, p_data}))
      stall_viol++;
    p_req  = mem_req_o;
    p_gnt  = mem_gnt_i;
    p_we   = mem_we_o;
    p_addr = mem_addr_o;
    p_data = mem_data_o;
  end

  // abort_cyc > 0: abort pulsed in that cycle (a READ cycle, grant always high);
  // abort_cyc == 0: abort raised together with start. restart_cyc > 0: extra start pulse.
  task automatic run_copy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                          input int len, input int mode, input int abort_cyc, input int restart_cyc);
    logic [31:0] sa, da, v;
    logic [64:0] exp_q[$];
    int nw, done_cnt, done_cyc, busy_cnt, mism, n_cmp, exp_cyc;
    bit fin;
    gnt_mode = mode;
    for (int i = 0; i < 1024; i++) mdl[i] = ram[i];
    sa = {src[31:2], 2'b00};
    da = {dst[31:2], 2'b00};
    nw = (abort_cyc > 0) ? (abort_cyc - 1) / 2 : len;
    for (int i = 0; i < nw; i++) begin
      v = mdl[idx(sa + 32'(4 * i))];
      exp_q.push_back({1'b0, sa + 32'(4 * i), v});
      exp_q.push_back({1'b1, da + 32'(4 * i), v});
      mdl[idx(da + 32'(4 * i))] = v;
    end
    if (abort_cyc > 0) exp_q.push_back({1'b0, sa + 32'(4 * nw), mdl[idx(sa + 32'(4 * nw))]});

    @(posedge clk); #1;
    obs_q.delete();
    stall_viol = 0;
    start_i    = 1'b1;
    src_addr_i = src;
    dst_addr_i = dst;
    len_i      = LEN_W'(len);
    abort_i    = (abort_cyc == 0);
    done_cnt = 0; done_cyc = 0; busy_cnt = 0; fin = 0;
    for (int c = 1; c <= 400 && !fin; c++) begin
      @(posedge clk); #1;
      start_i = (c == restart_cyc);
      if (c == restart_cyc) begin
        src_addr_i = 32'h0;
        dst_addr_i = 32'h40;
        len_i      = LEN_W'(1);
      end
      abort_i = (c == abort_cyc);
      @(negedge clk);
      if (busy_o) busy_cnt++; else fin = 1;
      if (done_o) begin done_cnt++; done_cyc = c; end
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    check({tag, "/finished"}, 96'(fin), 96'd1);
    check({tag, "/done_count"}, 96'(done_cnt), (abort_cyc > 0) ? 96'd0 : 96'd1);
    if (mode == 0) begin
      exp_cyc = (len == 0) ? 1 : 2 * len + 1;
      check({tag, "/done_cycle"}, 96'(done_cyc), (abort_cyc > 0) ? 96'd0 : 96'(exp_cyc));
      check({tag, "/busy_cycles"}, 96'(busy_cnt), (abort_cyc > 0) ? 96'(abort_cyc) : 96'(exp_cyc));
    end
    check({tag, "/n_access"}, 96'(obs_q.size()), 96'(exp_q.size()));
    n_cmp = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n_cmp; i++)
      check($sformatf("%s/access%0d", tag, i), 96'(obs_q[i]), 96'(exp_q[i]));
    check({tag, "/stall_hold"}, 96'(stall_viol), 96'd0);
    mism = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== mdl[i]) mism++;
    check({tag, "/ram_image"}, 96'(mism), 96'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] <= $urandom;
    ram[64] <= 32'h11111111;
    ram[65] <= 32'h22222222;
    ram[66] <= 32'h33333333;
    ram[67] <= 32'h44444444;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check("reset/busy", 96'(busy_o), 96'd0);
    check("reset/done", 96'(done_o), 96'd0);
    check("reset/mem", 96'({mem_req_o, mem_we_o, mem_addr_o, mem_data_o}), 96'd0);
    @(posedge clk); #1 rst = 1'b0;

    run_copy("copy4",      32'h100,      32'h200,      4, 0, -1, -1);
    run_copy("zero",       32'h100,      32'h280,      0, 0, -1, -1);
    run_copy("stall",      32'h100,      32'h300,      2, 1, -1, -1);
    run_copy("abort",      32'h100,      32'h400,      8, 0,  5, -1);
    run_copy("wrap",       32'h103,      32'hFFFFFFFE, 2, 0, -1, -1);
    run_copy("restart",    32'h100,      32'h500,      5, 0, -1,  3);
    run_copy("abort_idle", 32'h104,      32'h540,      3, 0,  0, -1);

    // Reset while a WRITE is on the bus.
    gnt_mode = 0;
    @(posedge clk); #1;
    start_i = 1'b1; src_addr_i = 32'h100; dst_addr_i = 32'h600; len_i = LEN_W'(4);
    @(posedge clk); #1 start_i = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst/busy", 96'(busy_o), 96'd0);
    check("midrst/done", 96'(done_o), 96'd0);
    check("midrst/mem", 96'({mem_req_o, mem_we_o, mem_addr_o, mem_data_o}), 96'd0);
    run_copy("after_rst",  32'h100,      32'h620,      4, 0, -1, -1);

    for (int t = 0; t < 8; t++) begin
      run_copy($sformatf("rand%0d", t), 32'($urandom_range(0, 4095)), 32'($urandom_range(0, 4095)),
               int'($urandom_range(1, 24)), (t % 2 == 0) ? 2 : 0, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
